// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator: pixel width, tap numbering and FSM encoding.
// Tap k = 3*row + col within the 3x3 window, with row 0 at the top and col 0 at the left.
package sobel_pkg;

  localparam int BYTE_SIZE = 8;
  localparam int WIN_TAPS  = 9;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int tap_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

  // Returns the window row/col a tap should read from.
  // An edge tap that falls outside the image is redirected to the centre row/col (1).
  function automatic int edge_sel(input int i, input logic lo, input logic hi);
    if (i == 0 && lo) return 1;
    if (i == 2 && hi) return 1;
    return i;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-row delay line for the window generator.
// The read is combinational from the write slot, so dout is the value written 2**DEPTH_E enables ago.
module sobel_line_buf #(
  parameter int DEPTH_E = 9,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0]   mem [2**DEPTH_E];
  logic [DEPTH_E-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator with zero padding at the image border.
// Define SOBEL_WIN_BORDER_REPLICATE_EN to pad by replicating the nearest edge pixel instead of zero.
module sobel_window_gen #(
  parameter int IMAGE_WIDTH_E = 9,
  parameter int IMAGE_HIGHT_E = 9,
  parameter int BYTE_SIZE     = sobel_pkg::BYTE_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [BYTE_SIZE-1:0]   s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [9*BYTE_SIZE-1:0] m_win,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof
);
  import sobel_pkg::*;

  localparam logic [IMAGE_WIDTH_E-1:0] COL_LAST  = '1;
  localparam logic [IMAGE_HIGHT_E-1:0] ROW_LAST  = '1;
  localparam logic [IMAGE_WIDTH_E-1:0] COL_PEN   = COL_LAST - 1'b1;
  localparam logic [IMAGE_HIGHT_E-1:0] ROW_PEN   = ROW_LAST - 1'b1;
  localparam logic [IMAGE_WIDTH_E:0]   FILL_LAST = {1'b1, {IMAGE_WIDTH_E{1'b0}}};

  state_e                 state, state_nxt;
  logic [IMAGE_WIDTH_E:0] fill_cnt;
  logic [IMAGE_WIDTH_E-1:0] col;
  logic [IMAGE_HIGHT_E-1:0] row;
  logic [BYTE_SIZE-1:0]   win [WIN_TAPS];
  logic [BYTE_SIZE-1:0]   nxt [WIN_TAPS];
  logic [BYTE_SIZE-1:0]   pad [WIN_TAPS];
  logic [BYTE_SIZE-1:0]   pix_in, lb0_out, lb1_out;
  logic                   out_free, accept, drain_load, load, shift_en;
  logic                   at_top, at_bot, at_left, at_right;

  sobel_line_buf #(.DEPTH_E(IMAGE_WIDTH_E), .WIDTH(BYTE_SIZE)) lb0 (
    .clk(clk), .reset(reset), .en(shift_en), .din(pix_in), .dout(lb0_out)
  );
  sobel_line_buf #(.DEPTH_E(IMAGE_WIDTH_E), .WIDTH(BYTE_SIZE)) lb1 (
    .clk(clk), .reset(reset), .en(shift_en), .din(lb0_out), .dout(lb1_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    out_free   = !m_valid || m_ready;
    drain_load = 1'b0;
    case (state)
      FILL:    s_ready = 1'b1;
      RUN:     s_ready = out_free;
      DRAIN:   drain_load = out_free && !(m_valid && m_eof);
      default: state_nxt = FILL;
    endcase
    accept   = s_valid && s_ready;
    load     = (state == RUN && accept) || drain_load;
    shift_en = accept || drain_load;
    pix_in   = (state == DRAIN) ? '0 : s_data;
    case (state)
      FILL:    if (accept && fill_cnt == FILL_LAST) state_nxt = RUN;
      RUN:     if (accept && row == ROW_PEN && col == COL_PEN) state_nxt = DRAIN;
      DRAIN:   if (m_valid && m_eof && m_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fill_cnt <= '0;
    else if (state == FILL && accept) fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + 1'b1;
  end

  // Counters track the centre of the window that the next load will produce.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= col + 1'b1;
      if (col == COL_LAST) row <= row + 1'b1;
    end
  end

  always_comb begin
    nxt[TAP_TL] = win[TAP_TC];
    nxt[TAP_TC] = win[TAP_TR];
    nxt[TAP_TR] = lb1_out;
    nxt[TAP_ML] = win[TAP_MC];
    nxt[TAP_MC] = win[TAP_MR];
    nxt[TAP_MR] = lb0_out;
    nxt[TAP_BL] = win[TAP_BC];
    nxt[TAP_BC] = win[TAP_BR];
    nxt[TAP_BR] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (reset) win <= '{default: '0};
    else if (shift_en) win <= nxt;
  end

  assign at_top   = (row == '0);
  assign at_bot   = (row == ROW_LAST);
  assign at_left  = (col == '0);
  assign at_right = (col == COL_LAST);

  // The mask also hides stale line-buffer contents and the row wrap at the image edges.
  always_comb begin
    pad = '{default: '0};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
        pad[tap_idx(r, c)] = nxt[tap_idx(edge_sel(r, at_top, at_bot), edge_sel(c, at_left, at_right))];
`else
        if (edge_sel(r, at_top, at_bot) == r && edge_sel(c, at_left, at_right) == c)
          pad[tap_idx(r, c)] = nxt[tap_idx(r, c)];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_win   <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      for (int k = 0; k < WIN_TAPS; k++) m_win[BYTE_SIZE*k +: BYTE_SIZE] <= pad[k];
      m_sof   <= at_top && at_left;
      m_eol   <= at_right;
      m_eof   <= at_bot && at_right;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame fed with a 0..15 ramp.
// Expected windows come from a coordinate-based padding model plus hand-computed windows.
module tb_sobel_window_gen;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [7:0]  s_data;
  logic [71:0] m_win;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMAGE_WIDTH_E(2), .IMAGE_HIGHT_E(2), .BYTE_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  task automatic check_win(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] win9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [71:0] model_win(input int j);
    logic [71:0] w = '0;
    int r0, c0, rr, cc;
    r0 = j / W;
    c0 = j % W;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        rr = r0 + r - 1;
        cc = c0 + c - 1;
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        w[8*(3*r+c) +: 8] = 8'(rr * W + cc);
`else
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[8*(3*r+c) +: 8] = 8'(rr * W + cc);
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] hand_win(input int j);
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
    if (j == 0) return win9(0, 0, 1, 0, 0, 1, 4, 4, 5);
    if (j == 5) return win9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    return win9(10, 11, 11, 14, 15, 15, 14, 15, 15);
`else
    if (j == 0) return win9(0, 0, 0, 0, 0, 1, 0, 4, 5);
    if (j == 5) return win9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    return win9(10, 11, 0, 14, 15, 0, 0, 0, 0);
`endif
  endfunction

  task automatic run_frame(input bit rand_ready, input bit check_drain);
    int pix, nwin, cyc, acc5, drain_wins;
    bit done, seen_valid, hold_pend;
    logic [71:0] hold_win;
    logic [3:0]  hold_fl;
    pix = 0; nwin = 0; cyc = 0; acc5 = -10; drain_wins = 0;
    done = 1'b0; seen_valid = 1'b0; hold_pend = 1'b0;
    hold_win = '0; hold_fl = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (hold_pend) begin
        check_win("hold_win", m_win, hold_win);
        check_val("hold_flags", 32'({m_valid, m_sof, m_eol, m_eof}), 32'(hold_fl));
      end
      if (!seen_valid && m_valid) begin
        seen_valid = 1'b1;
        check_val("first_valid_cycle", cyc, acc5 + 1);
      end
      s_valid = (pix < NPIX);
      s_data  = 8'(pix);
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hold_pend = m_valid && !m_ready;
      if (hold_pend) begin
        check_val("stall_s_ready", 32'(s_ready), 0);
        hold_win = m_win;
        hold_fl  = {m_valid, m_sof, m_eol, m_eof};
      end
      if (pix == NPIX) check_val("drain_s_ready", 32'(s_ready), 0);
      if (m_valid && m_ready) begin
        check_win($sformatf("win%0d", nwin), m_win, model_win(nwin));
        check_val($sformatf("flags%0d", nwin), 32'({m_sof, m_eol, m_eof}),
                  32'({nwin == 0, nwin % W == W - 1, nwin == NPIX - 1}));
        if (nwin == 0 || nwin == 5 || nwin == 15)
          check_win($sformatf("hand_win%0d", nwin), m_win, hand_win(nwin));
        if (pix == NPIX) drain_wins++;
        if (nwin == NPIX - 1) done = 1'b1;
        nwin++;
      end
      if (s_valid && s_ready) begin
        if (pix == 5) acc5 = cyc;
        pix++;
      end
      cyc++;
    end
    check_val("frame_done", 32'(done), 1);
    check_val("win_count", nwin, NPIX);
    // With m_ready held high, window 10 is still in the output register when pixel 15 lands.
    if (check_drain) check_val("drain_wins", drain_wins, 6);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check_val("back_to_fill", 32'(s_ready), 1);
    check_val("idle_valid", 32'(m_valid), 0);
  endtask

  initial begin
    int acc, guard;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_valid", 32'(m_valid), 0);
    check_win("reset_win", m_win, '0);
    check_val("reset_flags", 32'({m_sof, m_eol, m_eof}), 0);
    check_val("reset_s_ready", 32'(s_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);

    acc = 0; guard = 0;
    while (acc < 7 && guard < 50) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(acc);
      m_ready = 1'b1;
      #1;
      if (s_ready) acc++;
      guard++;
    end
    check_val("partial_pixels", acc, 7);
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midreset_valid", 32'(m_valid), 0);
    check_val("midreset_s_ready", 32'(s_ready), 1);
    check_win("midreset_win", m_win, '0);

    run_frame(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
